// File: rtl/fixed_point_scaler.sv
// Multi-cycle barrel shifter: scales a fixed-point operand left or logically right,
// at most STEP positions per cycle. Optional macro SCALER_SATURATE_EN saturates overflowing left shifts.
module fixed_point_scaler #(
   parameter int WIDTH   = 52,
   parameter int SHAMT_W = 6,
   parameter int STEP    = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               dir,
   input  logic [SHAMT_W-1:0] shift_amount,
   input  logic [WIDTH-1:0]   data_in,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   data_out,
   output logic               overflow
);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t               state;
   state_t               state_next;
   logic [WIDTH-1:0]     work;
   logic [SHAMT_W-1:0]   remaining;
   logic [SHAMT_W-1:0]   remaining_next;
   logic [SHAMT_W-1:0]   step_n;
   logic                 dir_q;
   logic                 sticky;
   logic [WIDTH+STEP-1:0] left_ext;
   logic [WIDTH-1:0]     shifted;
   logic [WIDTH-1:0]     result;
   logic                 lost;
   logic                 ovf_final;
   logic                 last_step;

   // One step of the serial shift; left shifts widen by STEP so escaping bits can be seen.
   always_comb begin
      step_n = remaining;
      if (32'(remaining) > STEP)
         step_n = SHAMT_W'(STEP);
      left_ext       = {{STEP{1'b0}}, work} << step_n;
      shifted        = dir_q ? (work >> step_n) : left_ext[WIDTH-1:0];
      lost           = ~dir_q & (|left_ext[WIDTH+STEP-1:WIDTH]);
      remaining_next = remaining - step_n;
      last_step      = (remaining_next == '0);
      ovf_final      = sticky | lost;
      result         = shifted;
`ifdef SCALER_SATURATE_EN
      if (ovf_final)
         result = '1;
`endif
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = SHIFT;
         SHIFT:   if (last_step) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   assign busy = (state == SHIFT);

   // Operand capture on the accepting edge, then one shift step per edge until done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         work      <= '0;
         remaining <= '0;
         dir_q     <= 1'b0;
         sticky    <= 1'b0;
         done      <= 1'b0;
         data_out  <= '0;
         overflow  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            if (start) begin
               work      <= data_in;
               remaining <= shift_amount;
               dir_q     <= dir;
               sticky    <= 1'b0;
            end
         end else begin
            work      <= shifted;
            remaining <= remaining_next;
            sticky    <= ovf_final;
            if (last_step) begin
               done     <= 1'b1;
               data_out <= result;
               overflow <= ovf_final;
            end
         end
      end
   end

endmodule

// File: tb/tb_fixed_point_scaler.sv
// Directed testbench for fixed_point_scaler with default parameters.
module tb_fixed_point_scaler;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        dir = 1'b0;
   logic [5:0]  shift_amount = '0;
   logic [51:0] data_in = '0;
   logic        busy;
   logic        done;
   logic [51:0] data_out;
   logic        overflow;

   int passed = 0;
   int total  = 0;

   localparam logic [51:0] ALL_ONES = {52{1'b1}};

   fixed_point_scaler dut (
      .clk(clk), .rst(rst), .start(start), .dir(dir),
      .shift_amount(shift_amount), .data_in(data_in),
      .busy(busy), .done(done), .data_out(data_out), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Presents one request, lets the accepting edge take it, then counts step edges until done.
   task automatic run_op(input logic d, input logic [5:0] amt, input logic [51:0] val,
                         output int edges, output logic timed_out);
      @(negedge clk);
      start = 1'b1; dir = d; shift_amount = amt; data_in = val;
      @(posedge clk); #1;
      start = 1'b0;
      edges = 0;
      timed_out = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         edges++;
         if (done) begin
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; data_in = 52'h12345; shift_amount = 6'd3;
      repeat (3) @(posedge clk);
      #1;
      total++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", busy); else passed++;
      total++; if (done !== 1'b0) $display("[TB] FAIL reset_done got %b want 0", done); else passed++;
      total++; if (data_out !== 52'h0) $display("[TB] FAIL reset_data got %h want 0", data_out); else passed++;
      total++; if (overflow !== 1'b0) $display("[TB] FAIL reset_ovf got %b want 0", overflow); else passed++;
      @(negedge clk);
      start = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_left_scale();
      int e; logic to;
      run_op(1'b0, 6'd16, 52'h1, e, to);
      total++; if (to || e !== 4) $display("[TB] FAIL left_latency got %0d edges (timeout %b) want 4", e, to); else passed++;
      total++; if (data_out !== 52'h10000) $display("[TB] FAIL left_data got %h want 10000", data_out); else passed++;
      total++; if (overflow !== 1'b0) $display("[TB] FAIL left_ovf got %b want 0", overflow); else passed++;
   endtask

   task automatic test_right_scale();
      int e; logic to;
      run_op(1'b1, 6'd17, 52'hF0000, e, to);
      total++; if (to || e !== 5) $display("[TB] FAIL right_latency got %0d edges (timeout %b) want 5", e, to); else passed++;
      total++; if (data_out !== 52'h7) $display("[TB] FAIL right_data got %h want 7", data_out); else passed++;
      total++; if (overflow !== 1'b0) $display("[TB] FAIL right_ovf got %b want 0", overflow); else passed++;
   endtask

   task automatic test_overflow();
      int e; logic to; logic [51:0] exp_ovf;
`ifdef SCALER_SATURATE_EN
      exp_ovf = ALL_ONES;
`else
      exp_ovf = 52'h0;
`endif
      run_op(1'b0, 6'd1, 52'h8_0000_0000_0000, e, to);
      total++; if (to || e !== 1) $display("[TB] FAIL ovf_latency got %0d edges (timeout %b) want 1", e, to); else passed++;
      total++; if (overflow !== 1'b1) $display("[TB] FAIL ovf_flag got %b want 1", overflow); else passed++;
      total++; if (data_out !== exp_ovf) $display("[TB] FAIL ovf_data got %h want %h", data_out, exp_ovf); else passed++;
   endtask

   task automatic test_large_shift();
      int e; logic to; logic [51:0] exp_ovf;
`ifdef SCALER_SATURATE_EN
      exp_ovf = ALL_ONES;
`else
      exp_ovf = 52'h0;
`endif
      run_op(1'b0, 6'd60, 52'h123, e, to);
      total++; if (to || e !== 15) $display("[TB] FAIL big_left_latency got %0d edges (timeout %b) want 15", e, to); else passed++;
      total++; if (data_out !== exp_ovf) $display("[TB] FAIL big_left_data got %h want %h", data_out, exp_ovf); else passed++;
      total++; if (overflow !== 1'b1) $display("[TB] FAIL big_left_ovf got %b want 1", overflow); else passed++;
      run_op(1'b1, 6'd52, ALL_ONES, e, to);
      total++; if (to || e !== 13) $display("[TB] FAIL big_right_latency got %0d edges (timeout %b) want 13", e, to); else passed++;
      total++; if (data_out !== 52'h0) $display("[TB] FAIL big_right_data got %h want 0", data_out); else passed++;
      total++; if (overflow !== 1'b0) $display("[TB] FAIL big_right_ovf got %b want 0", overflow); else passed++;
   endtask

   task automatic test_back_to_back();
      int e; logic to;
      run_op(1'b0, 6'd0, 52'hABCDE, e, to);
      total++; if (to || e !== 1) $display("[TB] FAIL zero_latency got %0d edges (timeout %b) want 1", e, to); else passed++;
      total++; if (data_out !== 52'hABCDE) $display("[TB] FAIL zero_data got %h want abcde", data_out); else passed++;
      total++; if (overflow !== 1'b0) $display("[TB] FAIL zero_ovf got %b want 0", overflow); else passed++;
      // Still inside the done cycle: this start must be accepted.
      start = 1'b1; dir = 1'b0; shift_amount = 6'd8; data_in = 52'h5;
      @(posedge clk); #1;
      total++; if (busy !== 1'b1) $display("[TB] FAIL b2b_accept got busy %b want 1", busy); else passed++;
      start = 1'b1; shift_amount = 6'd0; data_in = 52'hFFFF; dir = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      total++; if (busy !== 1'b1 || done !== 1'b0) $display("[TB] FAIL b2b_step1 got busy %b done %b want 1 0", busy, done); else passed++;
      @(posedge clk); #1;
      total++; if (done !== 1'b1) $display("[TB] FAIL b2b_done got %b want 1", done); else passed++;
      total++; if (data_out !== 52'h500) $display("[TB] FAIL b2b_data got %h want 500", data_out); else passed++;
      @(posedge clk); #1;
      total++; if (busy !== 1'b0 || done !== 1'b0) $display("[TB] FAIL b2b_ignored got busy %b done %b want 0 0", busy, done); else passed++;
   endtask

   task automatic test_reset_mid();
      int e; logic to; int seen_done;
      @(negedge clk);
      start = 1'b1; dir = 1'b0; shift_amount = 6'd40; data_in = 52'hFF;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      total++; if (busy !== 1'b0 || done !== 1'b0) $display("[TB] FAIL midrst_ctrl got busy %b done %b want 0 0", busy, done); else passed++;
      total++; if (data_out !== 52'h0 || overflow !== 1'b0) $display("[TB] FAIL midrst_out got %h ovf %b want 0 0", data_out, overflow); else passed++;
      @(negedge clk);
      rst = 1'b0;
      seen_done = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (done || busy) seen_done++;
      end
      total++; if (seen_done !== 0) $display("[TB] FAIL midrst_quiet got %0d active cycles want 0", seen_done); else passed++;
      run_op(1'b0, 6'd40, 52'hFF, e, to);
      total++; if (to || e !== 10) $display("[TB] FAIL after_rst_latency got %0d edges (timeout %b) want 10", e, to); else passed++;
      total++; if (data_out !== 52'h00FF_0000_0000_00) $display("[TB] FAIL after_rst_data got %h want ff0000000000", data_out); else passed++;
      total++; if (overflow !== 1'b0) $display("[TB] FAIL after_rst_ovf got %b want 0", overflow); else passed++;
   endtask

   initial begin
      test_reset();
      test_left_scale();
      test_right_scale();
      test_overflow();
      test_large_shift();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/fixed_point_scaler.md
# fixed_point_scaler

- Multi-cycle barrel shifter for the fixed-point datapath; re-scales a WIDTH-bit fixed-point operand by a bit count supplied by the leading-set-bit locator.
- Left shift (scale up) or logical right shift (scale down), at most STEP bit positions per cycle.
- Handshake: start/busy/done.
- Sits downstream of the locator and upstream of the iterative arithmetic units. It applies, or undoes, the normalization the locator measures.

## Interface
- WIDTH, 52: operand and result width in bits.
- SHAMT_W, 6: shift-amount width in bits.
- STEP, 4: maximum bit positions shifted per cycle. Legal values are 1..WIDTH.
- clk  in  1  clock; rising-edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  request. Sampled only while busy=0.
- dir  in  1  shift direction: 0 = left (scale up), 1 = logical right (scale down).
- shift_amount  in  SHAMT_W  total bit positions to shift.
- data_in  in  WIDTH  operand.
- busy  out  1  high while an operation is in flight.
- done  out  1  single-cycle pulse: result valid.
- data_out  out  WIDTH  result. Held until the next accepted start.
- overflow  out  1  left shift discarded at least one set bit. Valid with done; held with data_out.

## Operation
- FSM states: IDLE, SHIFT.
- IDLE:
  - On a clock edge with start=1, latch data_in, dir and shift_amount.
  - Set busy=1, clear the internal sticky overflow, go to SHIFT.
- SHIFT, each edge:
  - n = min(STEP, remaining); shift the working register by n; remaining -= n.
  - Left shift: any set bit shifted out past bit WIDTH-1 sets sticky overflow.
  - Right shift: zero-fill; bits shifted out below bit 0 are discarded.
  - When remaining reaches 0, or was 0 on entry, go to IDLE on that same edge with these updates: busy cleared, done set for one cycle, data_out loaded, overflow loaded.
- Step count:
  - K = ceil(shift_amount/STEP) step edges, minimum 1.
  - shift_amount=0 takes exactly one step edge with n=0; data_out = data_in, overflow=0.
- shift_amount ≥ WIDTH:
  - Both directions give data_out=0.
  - Left shift also gives overflow=1 if data_in≠0.
  - No special-case logic; this falls out of the serial shifting.
- start while busy=1 is ignored; it is not queued.
- start in the cycle where done=1: accepted, because busy is already 0. This gives back-to-back operation.
- Inputs are sampled only on the accepting edge. Later changes to data_in, dir or shift_amount have no effect on the operation in flight.
- Reset asserted mid-operation aborts the operation immediately. FSM returns to IDLE; no done pulse is issued.

## Timing
- Reset values: busy=0, done=0, data_out=0, overflow=0, FSM=IDLE.
- Edge 0 = accepting edge. Step edges are 1..K.
- busy: high after edge 0, low after edge K.
- done: high for exactly the cycle after edge K.
- Latency: start to done = K+1 cycles.
- Issue interval: one operation every K+1 cycles when back-to-back.

## Configuration
- Macro: SCALER_SATURATE_EN.
- Defined: a left shift with overflow=1 returns data_out = all ones (2^WIDTH−1). overflow is still reported.
- Undefined: data_out is the truncated shift result; overflow only flags the loss.
- Right shifts behave identically in both builds.

## Test plan
- Reset: assert rst with start held high → busy=0, done=0, data_out=0, overflow=0. No operation starts until rst is released.
- Left scale, default parameters: data_in=0x1, dir=0, shift_amount=16 → K=4; done in cycle 5 after start; data_out=0x10000, overflow=0.
- Right scale: data_in=0xF0000, dir=1, shift_amount=17 → K=5; data_out=0x7, overflow=0.
- Overflow: data_in=bit 51 set, dir=0, shift_amount=1 → overflow=1.
  - Without macro: data_out=0.
  - With SCALER_SATURATE_EN: data_out=0xF_FFFF_FFFF_FFFF.
- Zero shift, then back-to-back: shift_amount=0 → done 2 cycles after start, data_out=data_in. A start in the done cycle is accepted; a start pulsed while busy=1 is ignored.
- Reset mid-operation: shift_amount=40; assert rst at step edge 3 → no done; outputs return to reset values. The next start completes normally: 10 step edges, done 11 cycles after start.
